object_bounce_ctrl: RTL
=======================

// Module: object_bounce_ctrl
// PURPOSE
//  Consumes the per-pixel collision flag from the collision detector and the
//  start-of-frame strobe, and owns the motion of one moving object (the smiley).
//  Latches collisions during the raster, then at each frame boundary reflects
//  velocity on object collision or screen-edge contact and advances the position.
//  Outputs the object's top-left pixel coordinate to the object drawer.
// PARAMETERS
//  INITIAL_X        280  reset top-left X, pixels
//  INITIAL_Y        185  reset top-left Y, pixels
//  X_SPEED          64   reset X velocity, fixed-point units/frame (+ = right)
//  Y_SPEED          128  reset Y velocity, fixed-point units/frame (+ = down)
//  OBJECT_WIDTH     32   object width, pixels
//  OBJECT_HEIGHT    32   object height, pixels
//  COOLDOWN_FRAMES  4    frames after a bounce during which collisions are ignored
// PORTS
//  clk           in   1   system clock, the single clock domain
//  reset         in   1   synchronous, active-high reset
//  startOfFrame  in   1   one-cycle strobe at the start of each VGA frame
//  collision     in   1   registered collision flag, high per overlapping pixel
//  topLeftX      out  11  signed object X, pixels
//  topLeftY      out  11  signed object Y, pixels
//  bounce        out  1   one-cycle pulse when an object-collision bounce is applied
//  cooling       out  1   high while in COOLDOWN
// BEHAVIOUR
//  - Internal state: posX/posY and velX/velY are signed 32-bit values in
//    FIXED_POINT_MULTIPLIER units (64, power of 2). topLeft = pos >>> 6
//    (arithmetic shift), registered.
//  - Reset values: pos = INITIAL*64, vel = (+X_SPEED, +Y_SPEED), pending = 0,
//    state = RUN, cnt = 0. Outputs: topLeftX = INITIAL_X, topLeftY = INITIAL_Y,
//    bounce = 0, cooling = 0.
//  - FSM states: RUN and COOLDOWN.
//    - In RUN, any cycle with collision = 1 sets the sticky flag pending.
//    - In COOLDOWN, collision is ignored.
//    - A collision arriving in the same cycle as startOfFrame counts for that frame.
//  - On startOfFrame, the next state is computed in this fixed order:
//    1. If pending: negate velX and velY, clear pending, set bounce = 1 for one
//       cycle. If COOLDOWN_FRAMES > 0: go to COOLDOWN with cnt = COOLDOWN_FRAMES.
//    2. Otherwise, if in COOLDOWN: decrement cnt. When cnt reaches 0, go to RUN.
//       Collisions are accepted from the next cycle.
//    3. Wall reflection uses the velocity from step 1 and the current position.
//       MAXX = (640 - OBJECT_WIDTH) * 64, MAXY = (480 - OBJECT_HEIGHT) * 64.
//       - posX <= 0 and velX < 0: negate velX. posX >= MAXX and velX > 0: negate velX.
//       - The same rule applies to Y.
//    4. pos = pos + vel, clamped to [0, MAX] per axis.
//  - Latency: topLeftX/Y, bounce and cooling update 1 cycle after the startOfFrame strobe.
//  - Positions never change between frames.
//  - Reset mid-frame or mid-cooldown returns to reset values on the next edge.
//    pending is discarded.
//  - Overflow: velocity magnitude is never larger than MAX, so 32 bits never wrap.
// STRUCTURE
//  - Shared package vga_game_pkg:
//    - FIXED_POINT_MULTIPLIER = 64 and FP_SHIFT = 6
//    - SCREEN_WIDTH = 640 and SCREEN_HEIGHT = 480
//    - typedef enum logic {RUN, COOLDOWN} bounce_state_t
//  - One sub-module, axis_reflect: holds one axis (pos, vel, min/max reflection,
//    clamp), instantiated twice (X, Y) with reflect/step controls from the FSM.
// TESTING
//  1. Reset, 3 startOfFrame strobes, no collision -> topLeft (281,187), (282,189),
//     (283,191); bounce = 0.
//  2. After test 1, collision held 5 cycles, then strobe -> topLeft (282,189),
//     bounce pulse of 1 cycle, cooling = 1.
//  3. During cooldown, collision every frame -> no further bounce. Cooling falls
//     on the 4th strobe after the bounce. A collision on the next frame bounces again.
//  4. INITIAL_X = 607 -> strobe 1: X = 608. Strobe 2: velX negated, X = 607.
//     Y is unaffected.
//  5. collision and startOfFrame in the same cycle -> bounce applies on that frame
//     (position steps back).
//  6. Assert reset during cooldown with pending = 1 -> next cycle outputs
//     (280,185), cooling = 0, and no bounce on the following strobe.

Source files
------------

// File: rtl/vga_game_pkg.sv
// Shared constants and types for the VGA game blocks: fixed-point scaling,
// screen geometry and the bounce controller state encoding.
package vga_game_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT               = 6;
    localparam int SCREEN_WIDTH           = 640;
    localparam int SCREEN_HEIGHT          = 480;

    typedef enum logic {
        RUN      = 1'b0,
        COOLDOWN = 1'b1
    } bounce_state_t;

    // Fixed-point position to signed pixel coordinate (arithmetic shift keeps sign).
    function automatic logic signed [10:0] to_pixel(input logic signed [31:0] fp);
        logic signed [31:0] sh;
        sh = fp >>> FP_SHIFT;
        return sh[10:0];
    endfunction

endpackage

// File: rtl/object_bounce_ctrl_if.sv
// Frame/collision inputs and object position outputs of the bounce controller.
interface object_bounce_ctrl_if;

    logic               startOfFrame;
    logic               collision;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               bounce;
    logic               cooling;

    modport master (
        output startOfFrame, collision,
        input  topLeftX, topLeftY, bounce, cooling
    );

    modport slave (
        input  startOfFrame, collision,
        output topLeftX, topLeftY, bounce, cooling
    );

endinterface

// File: rtl/axis_reflect.sv
// One motion axis: fixed-point position and velocity, edge reflection,
// clamped stepping and a registered pixel coordinate.
module axis_reflect
    import vga_game_pkg::*;
#(
    parameter int INIT_PIX = 0,
    parameter int INIT_VEL = 0,
    parameter int MAX_PIX  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_i,
    input  logic               negate_i,
    output logic signed [10:0] top_left_o
);

    localparam logic signed [31:0] INIT_POS = 32'(INIT_PIX * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] MAX_POS  = 32'(MAX_PIX * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] VEL_RST  = 32'(INIT_VEL);

    logic signed [31:0] pos_q, pos_d;
    logic signed [31:0] vel_q, vel_d;
    logic signed [31:0] vel_n_s, vel_w_s, sum_s;
    logic signed [10:0] tl_q, tl_d;

    // Object bounce first, then wall reflection on the current position, then a clamped step.
    always_comb begin
        pos_d   = pos_q;
        vel_d   = vel_q;
        vel_n_s = negate_i ? -vel_q : vel_q;
        vel_w_s = vel_n_s;
        sum_s   = pos_q;
        if (((pos_q <= 32'sd0) && (vel_n_s < 32'sd0)) ||
            ((pos_q >= MAX_POS) && (vel_n_s > 32'sd0))) begin
            vel_w_s = -vel_n_s;
        end else begin
            vel_w_s = vel_n_s;
        end
        if (step_i) begin
            vel_d = vel_w_s;
            sum_s = pos_q + vel_w_s;
            if (sum_s < 32'sd0) begin
                pos_d = 32'sd0;
            end else if (sum_s > MAX_POS) begin
                pos_d = MAX_POS;
            end else begin
                pos_d = sum_s;
            end
        end else begin
            pos_d = pos_q;
            vel_d = vel_q;
        end
        tl_d = to_pixel(pos_d);
    end

    // Axis state and pixel output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= INIT_POS;
            vel_q <= VEL_RST;
            tl_q  <= to_pixel(INIT_POS);
        end else begin
            pos_q <= pos_d;
            vel_q <= vel_d;
            tl_q  <= tl_d;
        end
    end

    assign top_left_o = tl_q;

endmodule

// File: rtl/object_bounce_ctrl.sv
// Moves one object per frame: latches collisions during the raster and applies
// a bounce plus cooldown at the frame boundary, driving both axis units.
module object_bounce_ctrl
    import vga_game_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int X_SPEED         = 64,
    parameter int Y_SPEED         = 128,
    parameter int OBJECT_WIDTH    = 32,
    parameter int OBJECT_HEIGHT   = 32,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    object_bounce_ctrl_if.slave  bus
);

    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);

    bounce_state_t state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          hit_s;
    logic          bounce_d, bounce_q;
    logic          cooling_q;
    logic signed [10:0] tlx_s, tly_s;

    // Next-state: a collision coincident with the strobe still counts for this frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        bounce_d  = 1'b0;
        hit_s     = pending_q | ((state_q == RUN) & bus.collision);
        if (bus.startOfFrame) begin
            if (hit_s) begin
                pending_d = 1'b0;
                bounce_d  = 1'b1;
                if (COOLDOWN_FRAMES > 0) begin
                    state_d = COOLDOWN;
                    cnt_d   = CD_LOAD;
                end else begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end
            end else if (state_q == COOLDOWN) begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = RUN;
                end else begin
                    state_d = COOLDOWN;
                end
            end else begin
                pending_d = 1'b0;
            end
        end else begin
            pending_d = hit_s;
        end
    end

    // FSM, pending flag and status output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= 8'd0;
            pending_q <= 1'b0;
            bounce_q  <= 1'b0;
            cooling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            bounce_q  <= bounce_d;
            cooling_q <= (state_d == COOLDOWN);
        end
    end

    axis_reflect #(
        .INIT_PIX (INITIAL_X),
        .INIT_VEL (X_SPEED),
        .MAX_PIX  (SCREEN_WIDTH - OBJECT_WIDTH)
    ) u_axis_x (
        .clk        (clk),
        .reset      (reset),
        .step_i     (bus.startOfFrame),
        .negate_i   (bounce_d),
        .top_left_o (tlx_s)
    );

    axis_reflect #(
        .INIT_PIX (INITIAL_Y),
        .INIT_VEL (Y_SPEED),
        .MAX_PIX  (SCREEN_HEIGHT - OBJECT_HEIGHT)
    ) u_axis_y (
        .clk        (clk),
        .reset      (reset),
        .step_i     (bus.startOfFrame),
        .negate_i   (bounce_d),
        .top_left_o (tly_s)
    );

    assign bus.topLeftX = tlx_s;
    assign bus.topLeftY = tly_s;
    assign bus.bounce   = bounce_q;
    assign bus.cooling  = cooling_q;

endmodule
